// File: rtl/connect_join_arb_if.sv
// Bundle of the N-to-1 join: per-channel valid/ready/data inputs plus the single
// tagged output stream. The join uses the slave modport; its environment uses master.
interface connect_join_arb_if #(
  parameter int unsigned DATA_WIDTH   = 192,
  parameter int unsigned CONNECT_NUM  = 4,
  parameter int unsigned SOURCE_WIDTH = 2
);
  logic [CONNECT_NUM-1:0]            RECEIVE_VALID;
  logic [CONNECT_NUM-1:0]            RECEIVE_READY;
  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA;
  logic                              SEND_VALID;
  logic                              SEND_READY;
  logic [DATA_WIDTH-1:0]             SEND_DATA;
  logic [SOURCE_WIDTH-1:0]           SEND_SOURCE;

  modport slave (
    input  RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
    output RECEIVE_READY, SEND_VALID, SEND_DATA, SEND_SOURCE
  );

  modport master (
    output RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
    input  RECEIVE_READY, SEND_VALID, SEND_DATA, SEND_SOURCE
  );
endinterface

// File: rtl/connect_join_arb.sv
// N-to-1 valid/ready join: fixed-priority or round-robin grant into a small
// registered FIFO whose entries carry the winning channel index.
module connect_join_arb #(
  parameter int unsigned DATA_WIDTH   = 192,
  parameter int unsigned CONNECT_NUM  = 4,
  parameter int unsigned SOURCE_WIDTH = 2,
  parameter int unsigned ARB_MODE     = 0,
  parameter int unsigned OUT_DEPTH    = 2
) (
  input logic               CLK,
  input logic               RST,
  connect_join_arb_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(CONNECT_NUM);

  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [SOURCE_WIDTH-1:0] rr_ptr;
  logic [SOURCE_WIDTH-1:0] rr_next;
  logic [SOURCE_WIDTH-1:0] gnt_idx;
  logic                    found;
  logic                    can_push;
  logic                    push;
  logic                    pop;
  logic                    send_valid;
  logic [CONNECT_NUM-1:0]  grant;
  logic [DATA_WIDTH-1:0]   push_data;
  logic [DATA_WIDTH-1:0]   data_mem [OUT_DEPTH];
  logic [SOURCE_WIDTH-1:0] src_mem  [OUT_DEPTH];

  // Acceptance depends only on registered occupancy, so SEND_READY never reaches RECEIVE_READY.
  assign can_push = count < CNT_W'(OUT_DEPTH);

  // Winner search: ascending scan in fixed mode so the highest valid index is kept last;
  // descending offset scan in round-robin mode so the smallest offset from rr_ptr is kept last.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < CONNECT_NUM; i++) begin
        if (bus.RECEIVE_VALID[IDX_W'(i)]) begin
          found   = 1'b1;
          gnt_idx = SOURCE_WIDTH'(i);
        end
      end
    end else begin
      for (int k = CONNECT_NUM - 1; k >= 0; k--) begin
        int unsigned idx;
        idx = (int'(rr_ptr) + k) % CONNECT_NUM;
        if (bus.RECEIVE_VALID[IDX_W'(idx)]) begin
          found   = 1'b1;
          gnt_idx = SOURCE_WIDTH'(idx);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found && can_push && RST) begin
      grant = CONNECT_NUM'(1) << gnt_idx;
    end
  end

  always_comb begin
    push_data = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (gnt_idx == SOURCE_WIDTH'(i)) begin
        push_data = bus.RECEIVE_DATA[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign push    = |grant;
  assign pop     = send_valid && bus.SEND_READY;
  assign rr_next = (gnt_idx == SOURCE_WIDTH'(CONNECT_NUM - 1)) ? '0 : gnt_idx + SOURCE_WIDTH'(1);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // FIFO storage, pointers, occupancy and round-robin pointer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rr_ptr     <= '0;
      send_valid <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        data_mem[i] <= '0;
        src_mem[i]  <= '0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        src_mem[wr_ptr]  <= gnt_idx;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        rr_ptr           <= rr_next;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count      <= count_next;
      send_valid <= count_next != '0;
    end
  end

  assign bus.RECEIVE_READY = grant;
  assign bus.SEND_VALID    = send_valid;
  assign bus.SEND_DATA     = data_mem[rd_ptr];
  assign bus.SEND_SOURCE   = src_mem[rd_ptr];

endmodule

// File: tb/tb_connect_join_arb.sv
// Bench for connect_join_arb: one fixed-priority and one round-robin instance,
// checked every cycle against a reference occupancy/arbiter model and packet queue.
module tb_connect_join_arb;

  localparam int unsigned DW    = 192;
  localparam int unsigned N     = 4;
  localparam int unsigned SW    = 2;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
  } pkt_t;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    vld  [2];
  logic [N-1:0]    en   [2];
  logic [N-1:0]    acc  [2];
  bit              rnd  [2];
  bit              srnd [2];
  logic            sr   [2];
  logic [DW*N-1:0] rdat [2];

  int   m_cnt [2];
  int   m_rr  [2];
  pkt_t exp0[$];
  pkt_t exp1[$];
  int   log0[$];
  int   log1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [7];

  always #5 clk = ~clk;

  connect_join_arb_if #(.DATA_WIDTH(DW), .CONNECT_NUM(N), .SOURCE_WIDTH(SW)) b0 ();
  connect_join_arb_if #(.DATA_WIDTH(DW), .CONNECT_NUM(N), .SOURCE_WIDTH(SW)) b1 ();

  assign b0.RECEIVE_VALID = vld[0];
  assign b0.RECEIVE_DATA  = rdat[0];
  assign b0.SEND_READY    = sr[0];
  assign b1.RECEIVE_VALID = vld[1];
  assign b1.RECEIVE_DATA  = rdat[1];
  assign b1.SEND_READY    = sr[1];

  connect_join_arb #(.DATA_WIDTH(DW), .CONNECT_NUM(N), .SOURCE_WIDTH(SW),
                     .ARB_MODE(0), .OUT_DEPTH(DEPTH)) dut0 (.CLK(clk), .RST(rst_n), .bus(b0));
  connect_join_arb #(.DATA_WIDTH(DW), .CONNECT_NUM(N), .SOURCE_WIDTH(SW),
                     .ARB_MODE(1), .OUT_DEPTH(DEPTH)) dut1 (.CLK(clk), .RST(rst_n), .bus(b1));

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model evaluated on the falling edge for the upcoming rising edge.
  task automatic mon(input int m, input logic [N-1:0] v, input logic [N-1:0] r,
                     input logic [DW*N-1:0] d, input logic sv, input logic srdy,
                     input logic [DW-1:0] sd, input logic [SW-1:0] ss);
    pkt_t         head;
    pkt_t         p;
    logic [N-1:0] eg;
    int           g;
    bit           can;
    bit           pop;
    if (!rst_n) begin
      chk($sformatf("rst_ready%0d", m), DW'(r), '0);
      chk($sformatf("rst_send_valid%0d", m), DW'(sv), '0);
      m_cnt[m] = 0;
      m_rr[m]  = 0;
      acc[m]   = '0;
      if (m == 0) exp0.delete(); else exp1.delete();
    end else begin
      can = m_cnt[m] < int'(DEPTH);
      g   = -1;
      if (m == 0) begin
        for (int i = N - 1; i >= 0; i--) if (g < 0 && v[i]) g = i;
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_rr[m] + k) % N;
          if (g < 0 && v[c]) g = c;
        end
      end
      eg = (can && g >= 0) ? (N'(1) << g) : '0;
      chk($sformatf("ready%0d", m), DW'(r), DW'(eg));
      chk($sformatf("send_valid%0d", m), DW'(sv), DW'(m_cnt[m] != 0));
      head = '{src: '0, data: '0};
      if (m_cnt[m] != 0) begin
        head = (m == 0) ? exp0[0] : exp1[0];
        chk($sformatf("send_data%0d", m), sd, head.data);
        chk($sformatf("send_source%0d", m), DW'(ss), DW'(head.src));
      end
      acc[m] = v & r;
      pop = (m_cnt[m] != 0) && srdy;
      if (pop) begin
        if (m == 0) begin void'(exp0.pop_front()); log0.push_back(int'(head.src)); end
        else        begin void'(exp1.pop_front()); log1.push_back(int'(head.src)); end
      end
      if (eg != '0) begin
        p.src  = SW'(g);
        p.data = d[g*DW +: DW];
        if (m == 0) exp0.push_back(p); else exp1.push_back(p);
        m_rr[m] = (g + 1) % N;
      end
      m_cnt[m] = m_cnt[m] + ((eg != '0) ? 1 : 0) - (pop ? 1 : 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.RECEIVE_VALID, b0.RECEIVE_READY, b0.RECEIVE_DATA, b0.SEND_VALID,
        b0.SEND_READY, b0.SEND_DATA, b0.SEND_SOURCE);
    mon(1, b1.RECEIVE_VALID, b1.RECEIVE_READY, b1.RECEIVE_DATA, b1.SEND_VALID,
        b1.SEND_READY, b1.SEND_DATA, b1.SEND_SOURCE);
  end

  // Advance one cycle; senders drop accepted packets and optionally offer new ones.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[m][i]) vld[m][i] = 1'b0;
        if (!vld[m][i] && en[m][i] && (!rnd[m] || $urandom_range(1, 0) == 1)) begin
          vld[m][i] = 1'b1;
          rdat[m][i*DW +: DW] = rand_data();
        end
      end
      if (srnd[m]) sr[m] = ($urandom_range(3, 0) != 0);
    end
  endtask

  task automatic fill(input int m, input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      vld[m][i] = mask[i];
      if (mask[i]) rdat[m][i*DW +: DW] = rand_data();
    end
  endtask

  task automatic drain(input int m);
    en[m] = '0; rnd[m] = 0; srnd[m] = 0; sr[m] = 1'b1;
    for (int t = 0; t < 40; t++) if (vld[m] != '0 || m_cnt[m] != 0) tick();
    tick();
    #1 chk($sformatf("drained%0d", m), DW'((m == 0) ? b0.SEND_VALID : b1.SEND_VALID), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b0001, 4'b0001};
    tbl[2] = '{4'b0011, 4'b0010};
    tbl[3] = '{4'b0110, 4'b0100};
    tbl[4] = '{4'b1010, 4'b1000};
    tbl[5] = '{4'b1111, 4'b1000};
    tbl[6] = '{4'b0101, 4'b0100};

    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      en[m] = '0; rnd[m] = 0; srnd[m] = 0; sr[m] = 1'b0; acc[m] = '0; rdat[m] = '0;
      m_cnt[m] = 0; m_rr[m] = 0;
      fill(m, 4'b1111);
    end

    // Reset held with every channel valid, then released with no downstream ready.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_ready0", DW'(b0.RECEIVE_READY), '0);
    chk("rst_hold_ready1", DW'(b1.RECEIVE_READY), '0);
    chk("rst_hold_svalid0", DW'(b0.SEND_VALID), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vld[1] = '0;
    #1 chk("rel_ch3", DW'(b0.RECEIVE_READY), DW'(4'b1000));
    tick();
    #1 chk("rel_ch2", DW'(b0.RECEIVE_READY), DW'(4'b0100));
    tick();
    #1 chk("rel_full", DW'(b0.RECEIVE_READY), DW'(4'b0000));
    chk("rel_svalid", DW'(b0.SEND_VALID), DW'(1'b1));
    drain(0);

    // Fixed priority with all four channels presenting one packet each.
    fill(0, 4'b1111);
    log0.delete();
    sr[0] = 1'b1;
    for (int t = 0; t < 20 && log0.size() < 4; t++) tick();
    chk("fp_count", DW'(log0.size()), DW'(4));
    for (int k = 0; k < 4; k++) if (k < log0.size()) chk("fp_order", DW'(log0[k]), DW'(3 - k));
    drain(0);

    // Grant table for the fixed-priority instance.
    sr[0] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      fill(0, tbl[j].valid);
      #1 chk($sformatf("tbl%0d", j), DW'(b0.RECEIVE_READY), DW'(tbl[j].exp_ready));
      tick();
      vld[0] = '0;
    end
    drain(0);

    // Round-robin rotation over all channels.
    en[1] = 4'b1111; sr[1] = 1'b1;
    log1.delete();
    for (int t = 0; t < 40 && log1.size() < 8; t++) tick();
    drain(1);
    chk("rr_count", DW'(log1.size() >= 8), DW'(1'b1));
    for (int k = 0; k < 8; k++) if (k < log1.size()) chk("rr_order", DW'(log1[k]), DW'(k % 4));
    fill(1, 4'b0100);
    #1 chk("rr_only2", DW'(b1.RECEIVE_READY), DW'(4'b0100));
    tick();
    fill(1, 4'b1001);
    #1 chk("rr_ptr3", DW'(b1.RECEIVE_READY), DW'(4'b1000));
    tick();
    #1 chk("rr_wrap0", DW'(b1.RECEIVE_READY), DW'(4'b0001));
    drain(1);

    // Backpressure: full FIFO, stable head, then a pop with no same-cycle push.
    en[0] = 4'b1111; sr[0] = 1'b0;
    for (int t = 0; t < 10 && m_cnt[0] < 2; t++) tick();
    for (int t = 0; t < 10; t++) begin
      tick();
      #1 chk("bp_ready", DW'(b0.RECEIVE_READY), '0);
      chk("bp_head", b0.SEND_DATA, (exp0.size() > 0) ? exp0[0].data : '0);
    end
    sr[0] = 1'b1;
    #1 chk("bp_nobypass", DW'(b0.RECEIVE_READY), '0);
    tick();
    sr[0] = 1'b0;
    #1 chk("bp_push_next", DW'(b0.RECEIVE_READY), DW'(4'b1000));
    tick();
    #1 chk("bp_refull", DW'(b0.RECEIVE_READY), '0);
    drain(0);

    // Simultaneous push and pop with one entry resident.
    sr[0] = 1'b1;
    fill(0, 4'b0001);
    tick();
    fill(0, 4'b0001);
    tick();
    #1 chk("pp_valid", DW'(b0.SEND_VALID), DW'(1'b1));
    vld[0] = '0;
    tick();
    #1 chk("pp_empty", DW'(b0.SEND_VALID), '0);

    // Randomly timed senders on three channels with random downstream stalls.
    log0.delete(); log1.delete();
    for (int m = 0; m < 2; m++) begin en[m] = 4'b0111; rnd[m] = 1; srnd[m] = 1; end
    for (int t = 0; t < 3000 && (log0.size() < 100 || log1.size() < 100); t++) tick();
    chk("rand_pops0", DW'(log0.size() >= 100), DW'(1'b1));
    chk("rand_pops1", DW'(log1.size() >= 100), DW'(1'b1));
    drain(0);
    drain(1);

    // Reset with two entries resident: contents discarded.
    fill(0, 4'b1111);
    sr[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    vld[0] = '0;
    #1;
    chk("mrst_svalid", DW'(b0.SEND_VALID), '0);
    chk("mrst_sdata", b0.SEND_DATA, '0);
    chk("mrst_ready", DW'(b0.RECEIVE_READY), '0);
    tick();
    tick();
    rst_n = 1'b1;
    fill(0, 4'b0001);
    sr[0] = 1'b1;
    log0.delete();
    for (int t = 0; t < 10 && log0.size() < 1; t++) tick();
    chk("mrst_new_count", DW'(log0.size()), DW'(1));
    if (log0.size() > 0) chk("mrst_new_src", DW'(log0[0]), '0);
    drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
